unidade_controle_jogada: RTL
============================

// Module: unidade_controle_jogada
// PURPOSE
//  Moore FSM that sequences the game datapath (macro/micro registers, edge detector).
//  Per move it captures a macro-board choice, then a micro-cell choice.
//  It validates the macro choice, waits for the end-of-game check, then passes the
//  turn to the other player.
//  A per-move timeout counter forfeits the move when a player takes too long.
//  Sits between the top level and the datapath; drives every datapath control input.
// PARAMETERS
//  TIMEOUT_CICLOS  5000  clock cycles allowed per wait state before the move is forfeited
//  CW              13    timeout counter width; must satisfy 2**CW > TIMEOUT_CICLOS
// PORTS
//  clock            in   1  system clock, rising edge
//  reset            in   1  asynchronous, active-low reset (0 = reset)
//  jogar            in   1  start/restart request, level, sampled in inicial/fim
//  tem_jogada       in   1  1-cycle pulse from the datapath edge detector: button pressed
//  macro_livre      in   1  selected macro board is still open; valid in valida_macro
//  fim_jogo         in   1  win/draw detected by the datapath; valid in verifica
//  zeraEdge         out  1  clears the edge detector
//  zeraR_macro      out  1  clears the macro register
//  zeraR_micro      out  1  clears the micro register
//  registraR_macro  out  1  load enable, macro register
//  registraR_micro  out  1  load enable, micro register
//  vez              out  1  current player: 0 = X, 1 = O
//  pronto           out  1  game over
//  timeout          out  1  last turn change was caused by timeout
//  db_estado        out  4  current state code (debug)
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=inicial; vez=0; timeout=0; counter=0.
//   - All outputs 0, except db_estado=0000.
//  Outputs are decoded from the state register only (Moore), valid from the state's first cycle.
//  States (db_estado code), output=1 list, transitions:
//   0 inicial        -> preparacao if jogar.
//   1 preparacao     zeraEdge, zeraR_macro, zeraR_micro; vez<=0, timeout<=0, cnt<=0 -> espera_macro.
//   2 espera_macro   cnt++. tem_jogada -> registra_macro; else cnt==TIMEOUT_CICLOS-1 -> troca_jogador with timeout<=1.
//   3 registra_macro registraR_macro; cnt<=0 -> valida_macro.
//   4 valida_macro   macro_livre -> espera_micro; else -> espera_macro (board closed; choose again, cnt restarts).
//   5 espera_micro   cnt++. tem_jogada -> registra_micro; else timeout as in state 2.
//   6 registra_micro registraR_micro -> verifica.
//   7 verifica       one-cycle wait for datapath combinational check.
//                    fim_jogo -> fim; else -> troca_jogador with timeout<=0.
//   8 troca_jogador  zeraEdge; vez<=~vez; cnt<=0 -> espera_macro.
//   F fim            pronto; vez holds the last mover (winner/drawer) -> preparacao if jogar.
//   Codes 9..E are unreachable; if entered, go to inicial.
//  Boundary cases:
//   - tem_jogada has priority over timeout in the same cycle.
//   - Counter resets on every wait-state exit; it never wraps.
//   - tem_jogada is ignored outside states 2 and 5; no buffering.
//   - jogar held high in fim restarts immediately; one pulse suffices.
//   - timeout is sticky until the next verifica or preparacao.
//  Latency:
//   - tem_jogada in espera_macro -> registraR_macro high on the next cycle.
//   - Full move with valid macro, no timeout: tem_jogada(macro) ... tem_jogada(micro) -> troca 3 cycles later.
//   - Reset asserted mid-move aborts immediately to inicial; register contents are not cleared
//     until preparacao.
// TESTING
//  1 reset=0 then 1, jogar=0 -> db_estado=0, all control outputs 0 for 10 cycles.
//  2 jogar, tem_jogada(macro), macro_livre=1, tem_jogada(micro), fim_jogo=0
//    -> states 1,2,3,4,5,6,7,8,2; one cycle each of registraR_macro and registraR_micro; vez 0->1.
//  3 macro_livre=0 in valida_macro -> returns to state 2; registraR_micro never asserts; vez unchanged.
//  4 No tem_jogada for TIMEOUT_CICLOS cycles in state 2 (TIMEOUT_CICLOS=8 in bench)
//    -> state 8 after exactly 8 cycles in state 2; timeout=1; vez toggles.
//  5 tem_jogada on the timeout cycle -> registra_macro taken; timeout stays 0.
//  6 fim_jogo=1 in verifica -> pronto=1, vez holds. jogar -> preparacao, vez=0, pronto=0.
//    reset=0 mid state 5 -> db_estado=0 within the same cycle.

Source files
------------

// File: rtl/unidade_controle_jogada_if.sv
// Control/status bundle between the move-sequencing FSM and the game datapath.
// The master side is the controller; the slave side is the datapath (or top level).
interface unidade_controle_jogada_if;
    logic       jogar;
    logic       tem_jogada;
    logic       macro_livre;
    logic       fim_jogo;
    logic       zeraEdge;
    logic       zeraR_macro;
    logic       zeraR_micro;
    logic       registraR_macro;
    logic       registraR_micro;
    logic       vez;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  jogar, tem_jogada, macro_livre, fim_jogo,
        output zeraEdge, zeraR_macro, zeraR_micro, registraR_macro, registraR_micro,
        output vez, pronto, timeout, db_estado
    );

    modport slave (
        output jogar, tem_jogada, macro_livre, fim_jogo,
        input  zeraEdge, zeraR_macro, zeraR_micro, registraR_macro, registraR_micro,
        input  vez, pronto, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogada.sv
// Moore FSM sequencing one move (macro choice, then micro choice), with per-wait-state
// timeout that forfeits the move and hands the turn to the other player.
module unidade_controle_jogada #(
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned CW             = 13
) (
    input  logic                          clock,
    input  logic                          reset,
    unidade_controle_jogada_if.master     bus
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_MACRO   = 4'h2,
        REGISTRA_MACRO = 4'h3,
        VALIDA_MACRO   = 4'h4,
        ESPERA_MICRO   = 4'h5,
        REGISTRA_MICRO = 4'h6,
        VERIFICA       = 4'h7,
        TROCA_JOGADOR  = 4'h8,
        FIM            = 4'hF
    } estado_t;

    localparam logic [CW-1:0] CNT_ULTIMO = CW'(TIMEOUT_CICLOS - 1);

    estado_t       estado_q, estado_d;
    logic          vez_q, vez_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic zeraEdge_q;
    logic zeraR_macro_q;
    logic zeraR_micro_q;
    logic registraR_macro_q;
    logic registraR_micro_q;
    logic pronto_q;

    // vez/timeout changes are applied on the transition into the state that owns them,
    // so they are visible from that state's first cycle like the decoded outputs.
    always_comb begin
        estado_d  = estado_q;
        vez_d     = vez_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        unique case (estado_q)
            INICIAL, FIM: begin
                if (bus.jogar) begin
                    estado_d  = PREPARACAO;
                    vez_d     = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
            end

            PREPARACAO: begin
                estado_d = ESPERA_MACRO;
                cnt_d    = '0;
            end

            ESPERA_MACRO, ESPERA_MICRO: begin
                if (bus.tem_jogada) begin
                    estado_d = (estado_q == ESPERA_MACRO) ? REGISTRA_MACRO : REGISTRA_MICRO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_ULTIMO) begin
                    estado_d  = TROCA_JOGADOR;
                    vez_d     = ~vez_q;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            REGISTRA_MACRO: begin
                estado_d = VALIDA_MACRO;
                cnt_d    = '0;
            end

            VALIDA_MACRO: begin
                estado_d = bus.macro_livre ? ESPERA_MICRO : ESPERA_MACRO;
                cnt_d    = '0;
            end

            REGISTRA_MICRO: begin
                estado_d = VERIFICA;
            end

            VERIFICA: begin
                timeout_d = 1'b0;
                if (bus.fim_jogo) begin
                    estado_d = FIM;
                end else begin
                    estado_d = TROCA_JOGADOR;
                    vez_d    = ~vez_q;
                end
            end

            TROCA_JOGADOR: begin
                estado_d = ESPERA_MACRO;
                cnt_d    = '0;
            end

            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q          <= INICIAL;
            vez_q             <= 1'b0;
            timeout_q         <= 1'b0;
            cnt_q             <= '0;
            zeraEdge_q        <= 1'b0;
            zeraR_macro_q     <= 1'b0;
            zeraR_micro_q     <= 1'b0;
            registraR_macro_q <= 1'b0;
            registraR_micro_q <= 1'b0;
            pronto_q          <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            vez_q             <= vez_d;
            timeout_q         <= timeout_d;
            cnt_q             <= cnt_d;
            zeraEdge_q        <= (estado_d == PREPARACAO) || (estado_d == TROCA_JOGADOR);
            zeraR_macro_q     <= (estado_d == PREPARACAO);
            zeraR_micro_q     <= (estado_d == PREPARACAO);
            registraR_macro_q <= (estado_d == REGISTRA_MACRO);
            registraR_micro_q <= (estado_d == REGISTRA_MICRO);
            pronto_q          <= (estado_d == FIM);
        end
    end

    assign bus.zeraEdge        = zeraEdge_q;
    assign bus.zeraR_macro     = zeraR_macro_q;
    assign bus.zeraR_micro     = zeraR_micro_q;
    assign bus.registraR_macro = registraR_macro_q;
    assign bus.registraR_micro = registraR_micro_q;
    assign bus.vez             = vez_q;
    assign bus.pronto          = pronto_q;
    assign bus.timeout         = timeout_q;
    assign bus.db_estado       = estado_q;

endmodule
